// File: rtl/digit_counter.sv
// Multi-digit up/down event counter in a configurable radix with wrap or
// saturate policy and a freeze/resume control; one 4-bit nibble per digit.

module digit_cell #(
  parameter int RADIX = 16
) (
  input  logic [3:0] i_d,
  input  logic       i_cin,
  input  logic       i_bin,
  output logic [3:0] o_q,
  output logic       o_cout,
  output logic       o_bout
);
  localparam logic [3:0] MAXD = 4'(RADIX - 1);

  always_comb begin
    o_q    = i_d;
    o_cout = 1'b0;
    o_bout = 1'b0;
    if (i_cin) begin
      if (i_d == MAXD) begin
        o_q    = 4'd0;
        o_cout = 1'b1;
      end else begin
        o_q = i_d + 4'd1;
      end
    end else if (i_bin) begin
      if (i_d == 4'd0) begin
        o_q    = MAXD;
        o_bout = 1'b1;
      end else begin
        o_q = i_d - 4'd1;
      end
    end
  end
endmodule

module digit_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 16,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  max_tick,
  input  logic                  resume,
  output logic [DIGITS*4-1:0]   count,
  output logic                  paused,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  wrap_pulse
);
  logic [DIGITS-1:0][3:0] r_count;
  logic                   r_paused;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   r_wrap;

  logic [DIGITS-1:0][3:0] w_next;
  logic [DIGITS:0]        w_cy;
  logic [DIGITS:0]        w_bw;
  logic                   w_up;
  logic                   w_dn;
  logic                   w_ovf;
  logic                   w_unf;

  // inc&dec together cancel out: neither carry nor borrow enters the chain
  assign w_up    = inc & ~dec;
  assign w_dn    = dec & ~inc;
  assign w_cy[0] = w_up;
  assign w_bw[0] = w_dn;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      digit_cell #(.RADIX(RADIX)) u_cell (
        .i_d    (r_count[g]),
        .i_cin  (w_cy[g]),
        .i_bin  (w_bw[g]),
        .o_q    (w_next[g]),
        .o_cout (w_cy[g+1]),
        .o_bout (w_bw[g+1])
      );
    end
  endgenerate

  // carry/borrow out of the top digit means the count hit a limit
  assign w_ovf = w_cy[DIGITS];
  assign w_unf = w_bw[DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_paused    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (clear) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (max_tick) begin
        r_paused <= 1'b1;
      end else if (resume) begin
        r_paused <= 1'b0;
      end else if (!r_paused) begin
        if (w_ovf) r_overflow  <= 1'b1;
        if (w_unf) r_underflow <= 1'b1;
        // saturating variant holds the count at the limit instead of rolling
        if (WRAP || !(w_ovf || w_unf)) r_count <= w_next;
        if (WRAP && (w_ovf || w_unf))  r_wrap  <= 1'b1;
      end
    end
  end

  assign count      = r_count;
  assign paused     = r_paused;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign wrap_pulse = r_wrap;
endmodule

// File: tb/tb_digit_counter.sv
// Directed bench for digit_counter: hex/wrap, BCD/wrap and radix-4/saturate
// instances, each with its own control inputs and a shared clock and reset.

module tb_digit_counter;
  localparam int H = 0, B = 1, S = 2;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] clr, inc, dec, mtk, rsm;

  logic [15:0] h_cnt, b_cnt, s_cnt;
  logic h_pz, h_ov, h_un, h_wp;
  logic b_pz, b_ov, b_un, b_wp;
  logic s_pz, s_ov, s_un, s_wp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_counter #(.DIGITS(4), .RADIX(16), .WRAP(1'b1)) u_hex (
    .clk(clk), .reset(reset), .clear(clr[H]), .inc(inc[H]), .dec(dec[H]),
    .max_tick(mtk[H]), .resume(rsm[H]), .count(h_cnt), .paused(h_pz),
    .overflow(h_ov), .underflow(h_un), .wrap_pulse(h_wp));

  digit_counter #(.DIGITS(4), .RADIX(10), .WRAP(1'b1)) u_bcd (
    .clk(clk), .reset(reset), .clear(clr[B]), .inc(inc[B]), .dec(dec[B]),
    .max_tick(mtk[B]), .resume(rsm[B]), .count(b_cnt), .paused(b_pz),
    .overflow(b_ov), .underflow(b_un), .wrap_pulse(b_wp));

  digit_counter #(.DIGITS(4), .RADIX(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .clear(clr[S]), .inc(inc[S]), .dec(dec[S]),
    .max_tick(mtk[S]), .resume(rsm[S]), .count(s_cnt), .paused(s_pz),
    .overflow(s_ov), .underflow(s_un), .wrap_pulse(s_wp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k, input logic c, input logic i, input logic d,
                      input logic m, input logic r);
    clr = '0; inc = '0; dec = '0; mtk = '0; rsm = '0;
    clr[k] = c; inc[k] = i; dec[k] = d; mtk[k] = m; rsm[k] = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  initial begin
    reset = 1'b1;
    clr = '0; inc = '0; dec = '0; mtk = '0; rsm = '0;
    #3;
    chk("reset_hex", {h_cnt, h_pz, h_ov, h_un, h_wp}, 32'h0);
    chk("reset_bcd", {b_cnt, b_pz, b_ov, b_un, b_wp}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // hex ramp to 00FF, then carry across two digits
    for (int n = 1; n <= 255; n++) begin
      step(H, 0, 1, 0, 0, 0);
      chk("hex_ramp", h_cnt, n);
    end
    step(H, 0, 1, 0, 0, 0);
    chk("hex_0100", h_cnt, 32'h0100);
    chk("hex_0100_flags", {h_ov, h_wp}, 2'b00);

    // BCD ramp; every step compared against a decimal model
    for (int n = 1; n <= 999; n++) begin
      step(B, 0, 1, 0, 0, 0);
      chk("bcd_ramp", b_cnt, to_bcd(n));
    end
    step(B, 0, 1, 0, 0, 0);
    chk("bcd_1000", b_cnt, 32'h1000);
    chk("bcd_1000_wp", b_wp, 1'b0);
    step(B, 0, 0, 1, 0, 0);
    chk("bcd_0999", b_cnt, 32'h0999);

    // hex wrap in both directions
    step(H, 1, 0, 0, 0, 0);
    chk("hex_clear", {h_cnt, h_ov, h_un, h_wp}, 32'h0);
    step(H, 0, 0, 1, 0, 0);
    chk("hex_unf_cnt", h_cnt, 32'hFFFF);
    chk("hex_unf_flags", {h_ov, h_un, h_wp}, 3'b011);
    step(H, 0, 0, 0, 0, 0);
    chk("hex_wp_drop1", {h_cnt, h_wp}, {16'hFFFF, 1'b0});
    step(H, 0, 1, 0, 0, 0);
    chk("hex_ovf_cnt", h_cnt, 32'h0000);
    chk("hex_ovf_flags", {h_ov, h_un, h_wp}, 3'b111);
    step(H, 0, 0, 0, 0, 0);
    chk("hex_wp_drop2", {h_ov, h_un, h_wp}, 3'b110);
    step(H, 1, 0, 0, 0, 0);
    chk("hex_clear2", {h_cnt, h_ov, h_un, h_wp}, 32'h0);

    // saturating radix-4 counter: all-max is 3333
    for (int n = 1; n <= 255; n++) step(S, 0, 1, 0, 0, 0);
    chk("sat_max", {s_cnt, s_ov, s_wp}, {16'h3333, 2'b00});
    step(S, 0, 1, 0, 0, 0);
    chk("sat_ovf", {s_cnt, s_ov, s_un, s_wp}, {16'h3333, 3'b100});
    step(S, 1, 0, 0, 0, 0);
    chk("sat_clear", {s_cnt, s_ov, s_un}, 18'h0);
    step(S, 0, 0, 1, 0, 0);
    chk("sat_unf", {s_cnt, s_ov, s_un, s_wp}, {16'h0000, 3'b010});

    // freeze / resume
    for (int n = 1; n <= 5; n++) step(H, 0, 1, 0, 0, 0);
    chk("frz_pre", h_cnt, 32'h0005);
    step(H, 0, 1, 0, 1, 0);
    chk("frz_tick", {h_cnt, h_pz}, {16'h0005, 1'b1});
    for (int n = 0; n < 10; n++) step(H, 0, 1, 0, 0, 0);
    chk("frz_hold", {h_cnt, h_pz}, {16'h0005, 1'b1});
    step(H, 0, 1, 0, 0, 1);
    chk("frz_resume", {h_cnt, h_pz}, {16'h0005, 1'b0});
    step(H, 0, 1, 0, 0, 0);
    chk("frz_inc", h_cnt, 32'h0006);
    step(H, 0, 1, 1, 0, 0);
    chk("incdec", {h_cnt, h_ov, h_un, h_wp}, {16'h0006, 3'b000});

    // asynchronous reset mid-cycle
    step(H, 1, 0, 0, 0, 0);
    for (int n = 1; n <= 291; n++) step(H, 0, 1, 0, 0, 0);
    chk("pre_rst_cnt", h_cnt, 32'h0123);
    step(H, 0, 0, 0, 1, 0);
    chk("pre_rst_pz", h_pz, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_hex", {h_cnt, h_pz, h_ov, h_un, h_wp}, 32'h0);
    chk("async_rst_oth", {b_cnt, s_cnt, s_un}, 33'h0);
    #1;
    reset = 1'b0;
    step(H, 0, 1, 0, 0, 0);
    chk("post_rst_inc", {h_cnt, h_pz}, {16'h0001, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_counter.md
Name: digit_counter

Overview:
Parametrised multi-digit event counter. It is the successor of the fixed 4-digit hex sequence counter in the LFSR sequence detector path. It counts detected-sequence pulses in a configurable radix (hex or decimal) and digit count, with up/down counting, a wrap or saturate policy, and a freeze/resume control. Each digit output feeds one seven-segment digit driver.

Parameters:
DIGITS, 4, number of digits (1..8)
RADIX, 16, digit base (2..16); 10 gives BCD, 16 gives hex
WRAP, 1, 1 = roll over at the count limits; 0 = saturate at the count limits

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear of the count and sticky flags
inc  input  1  count-up request (one detected sequence), sampled each clk
dec  input  1  count-down request, sampled each clk
max_tick  input  1  freeze request; sets paused
resume  input  1  clears paused
count  output  DIGITS*4  digit vector; digit i occupies bits [4i+3:4i]; digit 0 is least significant
paused  output  1  registered freeze state
overflow  output  1  sticky; set on an increment at the all-max value
underflow  output  1  sticky; set on a decrement at zero
wrap_pulse  output  1  one-cycle pulse on any rollover in either direction

Behaviour:
- Reset (asynchronous, active-high): count=0, paused=0, overflow=0, underflow=0, wrap_pulse=0, all immediately, independent of clk. Deassertion takes effect from the next rising edge.
- All outputs are registered. A request sampled at edge N is visible after edge N.
- Per-cycle priority: clear > max_tick > resume > counting.
  - clear: count=0, overflow=0, underflow=0, wrap_pulse=0. paused is unchanged.
  - max_tick: paused<=1. Any count request in that cycle is ignored.
  - resume (with max_tick=0): paused<=0. A count request in the same cycle is ignored.
- Counting happens only when paused=0 and no higher-priority input is active. The effective step is:
  - inc&!dec: +1
  - dec&!inc: -1
  - inc&dec: no change, no flags
- Increment (ripple-carry decimal/hex style):
  - Digit 0 steps to +1.
  - A digit at RADIX-1 becomes 0 and carries into the next digit.
- Decrement:
  - A digit at 0 becomes RADIX-1 and borrows from the next digit.
- Increment at the all-max value (every digit RADIX-1):
  - WRAP=1: count<=0, overflow<=1, wrap_pulse=1 for one cycle.
  - WRAP=0: count is held, overflow<=1, wrap_pulse stays 0.
- Decrement at zero:
  - WRAP=1: every digit<=RADIX-1, underflow<=1, wrap_pulse=1 for one cycle.
  - WRAP=0: count is held at 0, underflow<=1.
- wrap_pulse is 0 in every cycle that did not roll over.
- The sticky flags clear only on reset or clear.
- Digit values never exceed RADIX-1. Bits above the radix range (e.g. BCD values 10..15) are unreachable from reset. An unused digit width is still 4 bits.
- While paused, count is frozen and flags do not change.
- Reset asserted mid-count overrides everything. The count in progress is discarded.
- inc and dec are level-sampled, one step per cycle while high. Edge detection is the producer's responsibility.

Test Plan:
1. DIGITS=4, RADIX=16: preload to 0x00FF via 255 inc pulses, then 1 inc -> count=0x0100, wrap_pulse=0, overflow=0.
2. RADIX=10: drive count to 0999, then inc -> count=1000 (digits 1,0,0,0); then 1 dec -> 0999; no digit ever shows a value above 9.
3. WRAP=1, RADIX=16: count=FFFF, inc -> count=0000, overflow=1, wrap_pulse high for exactly one cycle. Then dec -> FFFF, underflow=1, wrap_pulse pulses again. clear -> 0000 with both flags 0.
4. WRAP=0: count=FFFF, inc -> count stays FFFF, overflow=1, wrap_pulse=0. count=0000, dec -> stays 0000, underflow=1.
5. Freeze: count=0005, assert max_tick and inc in the same cycle -> count=0005, paused=1. Ten further inc -> still 0005. Assert resume with inc -> paused=0, count 0005. Next inc -> 0006. Then inc&dec together -> 0006 unchanged.
6. Reset: assert reset asynchronously between clk edges with count=0123 and paused=1 -> all outputs 0 before the next edge. Release reset, then inc -> 0001.
